// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction-memory request, tracks the
// fetch PC and fills the IF/ID register. A one-entry skid buffer absorbs a
// response that arrives while decode is stalled. Redirects flush the pipe,
// drain any in-flight request, and take priority over everything else.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        err
);

    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [15:0] r_pc;
    logic [15:0] r_drain_addr;
    logic [15:0] r_instr;
    logic [15:0] r_pc_plus2;
    logic        r_valid;
    logic        r_err;
    logic [15:0] r_skid_instr;
    logic [15:0] r_skid_pc_plus2;

    logic [15:0] w_pc_plus2;
    logic [15:0] w_redirect_pc;
    logic        w_data_is_halt;
    logic        w_skid_is_halt;
    logic        w_redirect_drains;

    assign w_pc_plus2        = r_pc + 16'd2;
    assign w_redirect_pc     = {redirect_pc[15:1], 1'b0};
    assign w_data_is_halt    = (imem_data[15:11] == 5'b00000);
    assign w_skid_is_halt    = (r_skid_instr[15:11] == 5'b00000);
    // A request that has already waited a cycle may still answer later, so a
    // redirect there must drain it instead of reissuing immediately.
    assign w_redirect_drains = (r_state == S_WAIT) && !imem_done;

    assign instr_out    = r_instr;
    assign pc_plus2_out = r_pc_plus2;
    assign valid_out    = r_valid;
    assign err          = r_err;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect overrides every other condition.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        if (redirect) begin
            w_next_state = w_redirect_drains ? S_DRAIN : S_REQ;
        end else begin
            unique case (r_state)
                S_REQ, S_WAIT: begin
                    if (imem_done) begin
                        if (stall)               w_next_state = S_HOLD;
                        else if (w_data_is_halt) w_next_state = S_HALT;
                        else                     w_next_state = S_REQ;
                    end else begin
                        w_next_state = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) w_next_state = w_skid_is_halt ? S_HALT : S_REQ;
                end
                S_DRAIN: begin
                    if (imem_done) w_next_state = S_REQ;
                end
                S_HALT:  w_next_state = S_HALT;
                default: w_next_state = S_REQ;
            endcase
        end
    end

    // Memory request outputs; no request is issued while reset is asserted.
    always_comb begin
        imem_rd   = 1'b0;
        imem_addr = r_pc;
        unique case (r_state)
            S_REQ, S_WAIT: imem_rd = rst;
            S_DRAIN: begin
                imem_rd   = rst;
                imem_addr = r_drain_addr;
            end
            default: imem_rd = 1'b0;
        endcase
    end

    // PC, IF/ID register, skid buffer and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc            <= 16'h0000;
            r_drain_addr    <= 16'h0000;
            r_instr         <= NOP;
            r_pc_plus2      <= 16'h0000;
            r_valid         <= 1'b0;
            r_err           <= 1'b0;
            // NOTE: the skid entry is cleared on reset even though HOLD is
            // the only reader, so its contents are never stale after reset.
            r_skid_instr    <= 16'h0000;
            r_skid_pc_plus2 <= 16'h0000;
        end else if (redirect) begin
            r_pc       <= w_redirect_pc;
            r_err      <= r_err | redirect_pc[0];
            r_instr    <= NOP;
            r_pc_plus2 <= 16'h0000;
            r_valid    <= 1'b0;
            if (w_redirect_drains) r_drain_addr <= r_pc;
        end else begin
            unique case (r_state)
                S_REQ, S_WAIT: begin
                    if (imem_done) begin
                        r_pc <= w_pc_plus2;
                        if (stall) begin
                            r_skid_instr    <= imem_data;
                            r_skid_pc_plus2 <= w_pc_plus2;
                        end else begin
                            r_instr    <= imem_data;
                            r_pc_plus2 <= w_pc_plus2;
                            r_valid    <= 1'b1;
                        end
                    end else if (!stall) begin
                        r_instr    <= NOP;
                        r_pc_plus2 <= 16'h0000;
                        r_valid    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_instr    <= r_skid_instr;
                        r_pc_plus2 <= r_skid_pc_plus2;
                        r_valid    <= 1'b1;
                    end
                end
                default: begin
                    if (!stall) begin
                        r_instr    <= NOP;
                        r_pc_plus2 <= 16'h0000;
                        r_valid    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural instruction memory with programmable
// latency, a transaction-level reference model of the fetch stage, directed
// scenarios followed by a randomized phase.
module tb_fetch_stage;

    localparam logic [15:0] NOP = 16'h0800;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
    } ifid_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_done;
    logic [15:0] imem_data;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic        err;

    int n_checks = 0;
    int n_err    = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_rd      (imem_rd),
        .imem_addr    (imem_addr),
        .imem_done    (imem_done),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Memory: 256 words, address bits [8:1] select the word.
    logic [15:0] mem [0:255];
    logic        mem_busy = 1'b0;
    logic [15:0] mem_cur  = 16'h0000;
    int          mem_cnt  = 0;
    int          mem_lat  = 0;
    int          lat_sel  = 0;   // <0 selects a random latency per request

    // Reference model state.
    ifid_t       m_ifid = '{NOP, 16'h0000, 1'b0};
    ifid_t       m_skid[$];
    logic [15:0] m_pc      = 16'h0000;
    logic [15:0] m_daddr   = 16'h0000;
    logic        m_err     = 1'b0;
    logic        m_halted  = 1'b0;
    logic        m_drain   = 1'b0;
    logic        m_waiting = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory answers the request currently on the bus; a new address starts
    // a fresh request with its own latency.
    task automatic mem_eval();
        if (!rst || !imem_rd) begin
            mem_busy  = 1'b0;
            imem_done = 1'b0;
            imem_data = 16'($urandom);
        end else begin
            if (!mem_busy || imem_addr != mem_cur) begin
                mem_busy = 1'b1;
                mem_cur  = imem_addr;
                mem_cnt  = 0;
                mem_lat  = (lat_sel < 0) ? int'($urandom_range(0, 2)) : lat_sel;
            end
            imem_done = (mem_cnt == mem_lat);
            imem_data = imem_done ? mem[mem_cur[8:1]] : 16'($urandom);
        end
    endtask

    task automatic mem_advance();
        if (mem_busy) begin
            if (imem_done) mem_busy = 1'b0;
            else           mem_cnt++;
        end
    endtask

    // Reference behaviour for one clock edge, from the current inputs.
    task automatic model_step();
        ifid_t e;
        logic  fetching;
        if (!rst) begin
            m_pc = 16'h0000; m_ifid = '{NOP, 16'h0000, 1'b0}; m_err = 1'b0;
            m_skid.delete(); m_halted = 1'b0; m_drain = 1'b0; m_waiting = 1'b0;
        end else if (redirect) begin
            fetching  = !m_halted && m_skid.size() == 0 && !m_drain;
            m_daddr   = m_pc;
            m_drain   = fetching && m_waiting && !imem_done;
            m_pc      = {redirect_pc[15:1], 1'b0};
            m_err     = m_err | redirect_pc[0];
            m_ifid    = '{NOP, 16'h0000, 1'b0};
            m_skid.delete();
            m_halted  = 1'b0;
            m_waiting = 1'b0;
        end else if (m_drain) begin
            if (imem_done) m_drain = 1'b0;
            if (!stall) m_ifid = '{NOP, 16'h0000, 1'b0};
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                m_ifid   = m_skid[0];
                m_halted = (m_skid[0].instr[15:11] == 5'b00000);
                m_skid.delete();
            end
        end else if (m_halted) begin
            if (!stall) m_ifid = '{NOP, 16'h0000, 1'b0};
        end else if (imem_done) begin
            e = '{imem_data, m_pc + 16'd2, 1'b1};
            if (stall) m_skid.push_back(e);
            else begin
                m_ifid   = e;
                m_halted = (imem_data[15:11] == 5'b00000);
            end
            m_pc      = m_pc + 16'd2;
            m_waiting = 1'b0;
        end else begin
            m_waiting = 1'b1;
            if (!stall) m_ifid = '{NOP, 16'h0000, 1'b0};
        end
    endtask

    // One clock cycle: check request outputs, drive inputs, step model,
    // then check registered outputs just after the edge.
    task automatic cycle(input logic s, input logic rd, input logic [15:0] rpc);
        logic exp_rd;
        @(negedge clk);
        exp_rd = rst && !m_halted && (m_skid.size() == 0);
        check("imem_rd", 16'(imem_rd), 16'(exp_rd));
        if (exp_rd) check("imem_addr", imem_addr, m_drain ? m_daddr : m_pc);
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        mem_eval();
        model_step();
        @(posedge clk);
        #1;
        mem_advance();
        check("instr_out", instr_out, m_ifid.instr);
        check("pc_plus2_out", pc_plus2_out, m_ifid.pp2);
        check("valid_out", 16'(valid_out), 16'(m_ifid.valid));
        check("err", 16'(err), 16'(m_err));
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_done = 1'b0; imem_data = 16'h0000;
        for (int i = 0; i < 256; i++)
            mem[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
        for (int i = 40; i < 256; i += 23) mem[i] = {5'b00000, 11'($urandom)};
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        mem[3] = 16'h4444; mem[4] = 16'h5555; mem[8] = 16'h0000;

        // Reset state.
        repeat (2) cycle(1'b0, 1'b0, 16'h0);
        check("rst_instr", instr_out, NOP);
        check("rst_valid", 16'(valid_out), 16'h0);
        check("rst_rd", 16'(imem_rd), 16'h0);

        // Back-to-back fetch with single-cycle memory.
        rst = 1'b1; lat_sel = 0;
        cycle(1'b0, 1'b0, 16'h0);
        check("b2b_instr0", instr_out, 16'h1111);
        check("b2b_pp2_0", pc_plus2_out, 16'h0002);
        cycle(1'b0, 1'b0, 16'h0);
        check("b2b_instr1", instr_out, 16'h2222);
        check("b2b_pp2_1", pc_plus2_out, 16'h0004);
        check("b2b_valid", 16'(valid_out), 16'h1);

        // Three-cycle memory delay.
        rst = 1'b0; cycle(1'b0, 1'b0, 16'h0);
        rst = 1'b1; lat_sel = 3;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 16'h0);
            check("slow_valid", 16'(valid_out), 16'h0);
            check("slow_addr", imem_addr, 16'h0000);
        end
        lat_sel = 0;
        cycle(1'b0, 1'b0, 16'h0);
        check("slow_instr", instr_out, 16'h1111);

        // Stall as the word at 4 returns.
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        check("hold_instr", instr_out, 16'h2222);
        check("hold_rd", 16'(imem_rd), 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        check("hold_pp2", pc_plus2_out, 16'h0004);
        cycle(1'b0, 1'b0, 16'h0);
        check("skid_instr", instr_out, 16'h3333);
        check("skid_pp2", pc_plus2_out, 16'h0006);

        // Redirect while waiting on address 8.
        cycle(1'b0, 1'b0, 16'h0);
        lat_sel = 3;
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0040);
        check("drain_addr", imem_addr, 16'h0008);
        cycle(1'b0, 1'b0, 16'h0);
        check("drain_valid", 16'(valid_out), 16'h0);
        lat_sel = 0;
        cycle(1'b0, 1'b0, 16'h0);
        check("drain_new_addr", imem_addr, 16'h0040);
        check("drain_instr", instr_out, NOP);

        // HALT word at 0x10, then resume at 0x20.
        cycle(1'b0, 1'b1, 16'h0010);
        cycle(1'b0, 1'b0, 16'h0);
        check("halt_instr", instr_out, 16'h0000);
        check("halt_valid", 16'(valid_out), 16'h1);
        repeat (2) cycle(1'b0, 1'b0, 16'h0);
        check("halt_rd", 16'(imem_rd), 16'h0);
        cycle(1'b0, 1'b1, 16'h0020);
        check("resume_addr", imem_addr, 16'h0020);

        // Misaligned redirect and PC wrap.
        cycle(1'b0, 1'b1, 16'h0031);
        check("mis_err", 16'(err), 16'h1);
        check("mis_addr", imem_addr, 16'h0030);
        cycle(1'b0, 1'b1, 16'hFFFE);
        cycle(1'b0, 1'b0, 16'h0);
        check("wrap_pp2", pc_plus2_out, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);
        check("err_sticky", 16'(err), 16'h1);
        rst = 1'b0; cycle(1'b0, 1'b0, 16'h0);
        check("err_clear", 16'(err), 16'h0);

        // Randomized traffic.
        lat_sel = -1;
        for (int i = 0; i < 600; i++) begin
            logic [15:0] rpc;
            int          r;
            rst = ($urandom_range(0, 99) >= 2);
            r = int'($urandom_range(0, 9));
            if (r == 0)      rpc = 16'hFFFC;
            else if (r == 1) rpc = 16'($urandom) | 16'h0001;
            else             rpc = 16'($urandom) & 16'hFFFE;
            cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 8), rpc);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
